xlr_job_sched: RTL and testbench

Batch job scheduler sitting between the XBOX memory interface and a single compute engine (for example the 2x2 MatMul datapath). The host programs a source line, destination line, job count and memory indices over the host register file, then starts the batch. For each job the block reads one 256-bit operand line, hands it to the engine over a valid/ready handshake, collects the 128-bit result and writes it back. Completion, progress and errors are reported through the status registers.

---
 rtl/xlr_sched_pkg.sv | 29 ++
 rtl/xlr_sched_regs.sv | 109 ++++++++++
 rtl/xlr_job_sched.sv | 151 +++++++++++++++
 tb/tb_xlr_job_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xlr_sched_pkg.sv
// Shared types and constants for the batch job scheduler.
// State encoding, host register map, byte-enable and error bit positions.
package xlr_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_ISSUE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } sched_state_t;

    localparam int REG_CTRL   = 0;
    localparam int REG_DONE   = 1;
    localparam int REG_CNT    = 2;
    localparam int REG_SRC    = 2;
    localparam int REG_DST    = 3;
    localparam int REG_ERR    = 3;
    localparam int REG_NJOBS  = 4;
    localparam int REG_MEMSEL = 5;

    localparam logic [31:0] BE_LOWER_HALF = 32'h0000_FFFF;

    localparam int ERR_BUSY   = 0;
    localparam int ERR_MEMSEL = 1;

endpackage

// File: rtl/xlr_sched_regs.sv
// Host-side register block: start qualification, config snapshot,
// sticky done/error flags and the status readback mux.
module xlr_sched_regs
    import xlr_sched_pkg::*;
#(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8,
    parameter int MEM_IDX_W          = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0][31:0]             i_host_regs,
    input  logic [31:0]                   i_host_valid,
    input  logic                          i_idle,
    input  logic                          i_done_set,
    input  logic [8:0]                    i_jobs,
    output logic                          o_start,
    output logic                          o_start_zero,
    output logic [LOG2_LINES_PER_MEM-1:0] o_src,
    output logic [LOG2_LINES_PER_MEM-1:0] o_dst,
    output logic [8:0]                    o_count,
    output logic [MEM_IDX_W-1:0]          o_src_mem,
    output logic [MEM_IDX_W-1:0]          o_dst_mem,
    output logic [31:0][31:0]             o_data,
    output logic [31:0]                   o_valid
);

    localparam int L = LOG2_LINES_PER_MEM;

    logic [L-1:0]         r_src;
    logic [L-1:0]         r_dst;
    logic [8:0]           r_count;
    logic [MEM_IDX_W-1:0] r_src_mem;
    logic [MEM_IDX_W-1:0] r_dst_mem;
    logic                 r_done;
    logic [1:0]           r_err;

    logic       w_start_req;
    logic [7:0] w_src_idx;
    logic [7:0] w_dst_idx;
    logic       w_bad_idx;
    logic       w_unused;

    assign w_start_req  = i_host_valid[REG_CTRL] && i_host_regs[REG_CTRL][0];
    assign w_src_idx    = i_host_regs[REG_MEMSEL][7:0];
    assign w_dst_idx    = i_host_regs[REG_MEMSEL][15:8];
    assign w_bad_idx    = ({24'b0, w_src_idx} >= 32'(NUM_MEMS))
                       || ({24'b0, w_dst_idx} >= 32'(NUM_MEMS));
    assign o_start      = w_start_req && i_idle && !w_bad_idx;
    assign o_start_zero = (i_host_regs[REG_NJOBS][8:0] == 9'd0);

    assign o_src     = r_src;
    assign o_dst     = r_dst;
    assign o_count   = r_count;
    assign o_src_mem = r_src_mem;
    assign o_dst_mem = r_dst_mem;

    assign w_unused = ^{i_host_regs[31:6],
                        i_host_regs[REG_MEMSEL][31:16],
                        i_host_regs[REG_NJOBS][31:9],
                        i_host_regs[REG_DST][31:L],
                        i_host_regs[REG_SRC][31:L],
                        i_host_regs[REG_DONE],
                        i_host_regs[REG_CTRL][31:1],
                        i_host_valid[31:1]};

    // Snapshot config on an accepted start; track sticky done and errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src     <= '0;
            r_dst     <= '0;
            r_count   <= '0;
            r_src_mem <= '0;
            r_dst_mem <= '0;
            r_done    <= 1'b0;
            r_err     <= 2'b00;
        end else begin
            if (o_start) begin
                r_src     <= i_host_regs[REG_SRC][L-1:0];
                r_dst     <= i_host_regs[REG_DST][L-1:0];
                r_count   <= i_host_regs[REG_NJOBS][8:0];
                r_src_mem <= w_src_idx[MEM_IDX_W-1:0];
                r_dst_mem <= w_dst_idx[MEM_IDX_W-1:0];
                r_err     <= 2'b00;
            end else begin
                if (w_start_req && !i_idle)
                    r_err[ERR_BUSY] <= 1'b1;
                if (w_start_req && i_idle && w_bad_idx)
                    r_err[ERR_MEMSEL] <= 1'b1;
            end
            // A zero-length batch enters DONE on the start edge itself.
            if (i_done_set)
                r_done <= 1'b1;
            else if (o_start)
                r_done <= 1'b0;
        end
    end

    // Status readback: only the first four registers are populated.
    always_comb begin
        o_data           = '0;
        o_data[REG_CTRL] = {31'b0, !i_idle};
        o_data[REG_DONE] = {31'b0, r_done};
        o_data[REG_CNT]  = {23'b0, i_jobs};
        o_data[REG_ERR]  = {30'b0, r_err};
        o_valid          = 32'h0000_000F;
    end

endmodule

// File: rtl/xlr_job_sched.sv
// Batch job scheduler: read operand line, hand to engine, collect
// the result and write it back, once per job in the batch.
module xlr_job_sched
    import xlr_sched_pkg::*;
#(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]      xlr_mem_addr,
    output logic [NUM_MEMS-1:0][7:0][31:0]                   xlr_mem_wdata,
    output logic [NUM_MEMS-1:0][31:0]                        xlr_mem_be,
    output logic [NUM_MEMS-1:0]                              xlr_mem_rd,
    output logic [NUM_MEMS-1:0]                              xlr_mem_wr,
    input  logic [NUM_MEMS-1:0][7:0][31:0]                   xlr_mem_rdata,
    input  logic [31:0][31:0]                                host_regs,
    input  logic [31:0]                                      host_regs_valid_pulse,
    output logic [31:0][31:0]                                host_regs_data_out,
    output logic [31:0]                                      host_regs_valid_out,
    output logic                                             eng_op_valid,
    input  logic                                             eng_op_ready,
    output logic [7:0][31:0]                                 eng_op_data,
    input  logic                                             eng_res_valid,
    output logic                                             eng_res_ready,
    input  logic [3:0][31:0]                                 eng_res_data
);

    localparam int L  = LOG2_LINES_PER_MEM;
    localparam int MW = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;

    sched_state_t r_state;
    sched_state_t w_next;

    logic [8:0]       r_jobs;
    logic [7:0][31:0] r_op;
    logic [3:0][31:0] r_res;

    logic          w_start;
    logic          w_start_zero;
    logic [L-1:0]  w_src;
    logic [L-1:0]  w_dst;
    logic [8:0]    w_count;
    logic [MW-1:0] w_src_mem;
    logic [MW-1:0] w_dst_mem;
    logic [L-1:0]  w_src_addr;
    logic [L-1:0]  w_dst_addr;
    logic          w_more;
    logic          w_done_set;

    xlr_sched_regs #(
        .NUM_MEMS           (NUM_MEMS),
        .LOG2_LINES_PER_MEM (L),
        .MEM_IDX_W          (MW)
    ) u_regs (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_host_regs  (host_regs),
        .i_host_valid (host_regs_valid_pulse),
        .i_idle       (r_state == S_IDLE),
        .i_done_set   (w_done_set),
        .i_jobs       (r_jobs),
        .o_start      (w_start),
        .o_start_zero (w_start_zero),
        .o_src        (w_src),
        .o_dst        (w_dst),
        .o_count      (w_count),
        .o_src_mem    (w_src_mem),
        .o_dst_mem    (w_dst_mem),
        .o_data       (host_regs_data_out),
        .o_valid      (host_regs_valid_out)
    );

    assign w_src_addr = w_src + r_jobs[L-1:0];
    assign w_dst_addr = w_dst + r_jobs[L-1:0];
    assign w_more     = ({1'b0, r_jobs} + 10'd1) < {1'b0, w_count};
    assign w_done_set = (w_next == S_DONE) && (r_state != S_DONE);

    assign eng_op_valid  = (r_state == S_ISSUE);
    assign eng_res_ready = (r_state == S_COLLECT);
    assign eng_op_data   = r_op;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:
                if (w_start)
                    w_next = w_start_zero ? S_DONE : S_RD_REQ;
            S_RD_REQ:  w_next = S_RD_WAIT;
            S_RD_WAIT: w_next = S_ISSUE;
            S_ISSUE:
                if (eng_op_ready)
                    w_next = S_COLLECT;
            S_COLLECT:
                if (eng_res_valid)
                    w_next = S_WRITE;
            S_WRITE:   w_next = w_more ? S_RD_REQ : S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Job counter, operand capture and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_jobs <= '0;
            r_op   <= '0;
            r_res  <= '0;
        end else begin
            if (w_start)
                r_jobs <= '0;
            else if (r_state == S_WRITE)
                r_jobs <= r_jobs + 9'd1;
            if (r_state == S_RD_WAIT)
                r_op <= xlr_mem_rdata[w_src_mem];
            if (r_state == S_COLLECT && eng_res_valid)
                r_res <= eng_res_data;
        end
    end

    // Memory strobes: only the selected instance sees non-zero drive.
    always_comb begin
        xlr_mem_addr  = '0;
        xlr_mem_wdata = '0;
        xlr_mem_be    = '0;
        xlr_mem_rd    = '0;
        xlr_mem_wr    = '0;
        for (int m = 0; m < NUM_MEMS; m++) begin
            if (r_state == S_RD_REQ && w_src_mem == MW'(m)) begin
                xlr_mem_rd[m]   = 1'b1;
                xlr_mem_addr[m] = w_src_addr;
            end
            if (r_state == S_WRITE && w_dst_mem == MW'(m)) begin
                xlr_mem_wr[m]    = 1'b1;
                xlr_mem_addr[m]  = w_dst_addr;
                xlr_mem_be[m]    = BE_LOWER_HALF;
                xlr_mem_wdata[m] = {128'b0, r_res};
            end
        end
    end

endmodule

// File: tb/tb_xlr_job_sched.sv
// Directed bench for xlr_job_sched with a line memory model
// and a 2x2 MatMul engine model with programmable stalls.
module tb_xlr_job_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [1:0][7:0]       xlr_mem_addr;
    logic [1:0][7:0][31:0] xlr_mem_wdata;
    logic [1:0][31:0]      xlr_mem_be;
    logic [1:0]            xlr_mem_rd;
    logic [1:0]            xlr_mem_wr;
    logic [1:0][7:0][31:0] xlr_mem_rdata = '0;
    logic [31:0][31:0]     host_regs = '0;
    logic [31:0]           host_regs_valid_pulse = '0;
    logic [31:0][31:0]     host_regs_data_out;
    logic [31:0]           host_regs_valid_out;
    logic                  eng_op_valid;
    logic                  eng_op_ready = 1'b0;
    logic [7:0][31:0]      eng_op_data;
    logic                  eng_res_valid = 1'b0;
    logic                  eng_res_ready;
    logic [3:0][31:0]      eng_res_data = '0;

    xlr_job_sched #(.NUM_MEMS(2), .LOG2_LINES_PER_MEM(8)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .xlr_mem_addr          (xlr_mem_addr),
        .xlr_mem_wdata         (xlr_mem_wdata),
        .xlr_mem_be            (xlr_mem_be),
        .xlr_mem_rd            (xlr_mem_rd),
        .xlr_mem_wr            (xlr_mem_wr),
        .xlr_mem_rdata         (xlr_mem_rdata),
        .host_regs             (host_regs),
        .host_regs_valid_pulse (host_regs_valid_pulse),
        .host_regs_data_out    (host_regs_data_out),
        .host_regs_valid_out   (host_regs_valid_out),
        .eng_op_valid          (eng_op_valid),
        .eng_op_ready          (eng_op_ready),
        .eng_op_data           (eng_op_data),
        .eng_res_valid         (eng_res_valid),
        .eng_res_ready         (eng_res_ready),
        .eng_res_data          (eng_res_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- memory model ----------------
    logic [255:0] mem [2][256];
    int           rd_log[$];
    int           wr_log[$];
    int           be_err = 0;
    logic         pl_v = 1'b0;
    int           pl_m = 0;
    logic [7:0]   pl_a = '0;
    logic [255:0] pl_d = '0;

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic [255:0] wl;
            if (xlr_mem_rd[m]) begin
                xlr_mem_rdata[m] <= mem[m][xlr_mem_addr[m]];
                rd_log.push_back(m * 256 + int'(xlr_mem_addr[m]));
            end
            if (xlr_mem_wr[m]) begin
                wl = xlr_mem_wdata[m];
                for (int b = 0; b < 32; b++)
                    if (xlr_mem_be[m][b])
                        mem[m][xlr_mem_addr[m]][b*8 +: 8] = wl[b*8 +: 8];
                wr_log.push_back(m * 256 + int'(xlr_mem_addr[m]));
                if (xlr_mem_be[m] !== 32'h0000_FFFF)
                    be_err++;
            end
        end
        if (pl_v)
            mem[pl_m][pl_a] = pl_d;
    end

    // ---------------- engine model ----------------
    function automatic logic [127:0] mm(input logic [255:0] l);
        logic [7:0][31:0] d;
        logic [3:0][31:0] c;
        d = l;
        c[0] = d[0] * d[4] + d[1] * d[6];
        c[1] = d[0] * d[5] + d[1] * d[7];
        c[2] = d[2] * d[4] + d[3] * d[6];
        c[3] = d[2] * d[5] + d[3] * d[7];
        return c;
    endfunction

    function automatic logic [255:0] mk(input int b);
        logic [7:0][31:0] d;
        for (int i = 0; i < 8; i++)
            d[i] = 32'(b + i);
        return d;
    endfunction

    int               op_delay  = 0;
    int               res_delay = 0;
    int               hs_cnt    = 0;
    int               stab_err  = 0;
    int               owait     = 0;
    int               rwait     = 0;
    logic             pend      = 1'b0;
    logic [3:0][31:0] eng_q     = '0;
    logic             hold_v    = 1'b0;
    logic [7:0][31:0] hold_d    = '0;

    always @(posedge clk) begin
        if (eng_op_valid && hold_v && eng_op_data !== hold_d)
            stab_err++;
        hold_v = eng_op_valid && !eng_op_ready;
        hold_d = eng_op_data;
        if (eng_res_valid && eng_res_ready)
            pend = 1'b0;
        if (eng_op_valid && eng_op_ready) begin
            hs_cnt++;
            eng_q = mm(eng_op_data);
            pend  = 1'b1;
            rwait = 0;
        end
    end

    always @(negedge clk) begin
        if (pend) begin
            if (rwait >= res_delay) begin
                eng_res_valid = 1'b1;
                eng_res_data  = eng_q;
            end else begin
                rwait++;
                eng_res_valid = 1'b0;
            end
        end else begin
            rwait         = 0;
            eng_res_valid = 1'b0;
        end
        if (eng_op_valid) begin
            if (owait >= op_delay) begin
                eng_op_ready = 1'b1;
            end else begin
                owait++;
                eng_op_ready = 1'b0;
            end
        end else begin
            owait        = 0;
            eng_op_ready = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input int m, input logic [7:0] a,
                           input logic [255:0] d);
        pl_m = m;
        pl_a = a;
        pl_d = d;
        pl_v = 1'b1;
        tick(1);
        pl_v = 1'b0;
    endtask

    task automatic start(input logic [7:0] s, input logic [7:0] d,
                         input logic [8:0] n, input logic [7:0] sm,
                         input logic [7:0] dm);
        host_regs[2] = {24'b0, s};
        host_regs[3] = {24'b0, d};
        host_regs[4] = {23'b0, n};
        host_regs[5] = {16'b0, dm, sm};
        host_regs[0] = 32'd1;
        host_regs_valid_pulse = 32'd1;
        tick(1);
        host_regs_valid_pulse = 32'd0;
        host_regs[0] = 32'd0;
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int c;
        c = 0;
        while (host_regs_data_out[0][0] && c < maxc) begin
            tick(1);
            c++;
        end
        chk(tag, host_regs_data_out[0], 0);
    endtask

    function automatic logic [83:0] strobes();
        return {xlr_mem_addr, xlr_mem_rd, xlr_mem_wr, xlr_mem_be};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0][31:0] exp_l;
        int r0, w0, h0, m0w;
        logic reached;

        rst_n = 1'b0;
        #2;
        chk("rst_strobes", strobes(), 0);
        chk("rst_wdata0", xlr_mem_wdata[0], 0);
        chk("rst_wdata1", xlr_mem_wdata[1], 0);
        chk("rst_eng", {eng_op_valid, eng_res_ready}, 0);
        chk("rst_busy", host_regs_data_out[0], 0);
        chk("rst_done", host_regs_data_out[1], 0);
        chk("rst_cnt", host_regs_data_out[2], 0);
        chk("rst_err", host_regs_data_out[3], 0);
        chk("rst_valid_out", host_regs_valid_out, 32'hF);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Single job, 1-cycle engine
        preload(0, 8'h00, mk(1));
        preload(1, 8'h01, {8{32'hAAAA_AAAA}});
        r0 = rd_log.size();
        w0 = wr_log.size();
        start(8'h00, 8'h01, 9'd1, 8'd0, 8'd1);
        chk("t1_busy", host_regs_data_out[0], 1);
        tick(4);
        chk("t1_done_early", host_regs_data_out[1], 0);
        tick(1);
        chk("t1_done_5cyc", host_regs_data_out[1], 1);
        tick(1);
        chk("t1_idle", host_regs_data_out[0], 0);
        chk("t1_jobs", host_regs_data_out[2], 1);
        exp_l = {{4{32'hAAAA_AAAA}}, 32'd50, 32'd43, 32'd22, 32'd19};
        chk("t1_line", mem[1][1], exp_l);
        chk("t1_nrd", rd_log.size() - r0, 1);
        chk("t1_rd0", rd_log[r0], 0);
        chk("t1_nwr", wr_log.size() - w0, 1);
        chk("t1_wr0", wr_log[w0], 256 + 1);
        chk("t1_be", be_err, 0);

        // Wrap-around of source and destination addresses
        preload(0, 8'hFE, mk(10));
        preload(0, 8'hFF, mk(20));
        preload(0, 8'h00, mk(30));
        preload(1, 8'hFF, '0);
        preload(1, 8'h00, '0);
        preload(1, 8'h01, '0);
        r0 = rd_log.size();
        w0 = wr_log.size();
        start(8'hFE, 8'hFF, 9'd3, 8'd0, 8'd1);
        chk("t2_done_cleared", host_regs_data_out[1], 0);
        wait_idle(100, "t2_finish");
        chk("t2_jobs", host_regs_data_out[2], 3);
        chk("t2_done", host_regs_data_out[1], 1);
        chk("t2_nrd", rd_log.size() - r0, 3);
        chk("t2_rd", {rd_log[r0], rd_log[r0+1], rd_log[r0+2]},
            {32'd254, 32'd255, 32'd0});
        chk("t2_nwr", wr_log.size() - w0, 3);
        chk("t2_wr", {wr_log[w0], wr_log[w0+1], wr_log[w0+2]},
            {32'd511, 32'd256, 32'd257});
        m0w = 0;
        for (int k = w0; k < wr_log.size(); k++)
            if (wr_log[k] < 256)
                m0w++;
        chk("t2_mem0_untouched", m0w, 0);
        chk("t2_line_ff", mem[1][8'hFF], {128'b0, mm(mk(10))});
        chk("t2_line_00", mem[1][8'h00], {128'b0, mm(mk(20))});
        chk("t2_line_01", mem[1][8'h01], {128'b0, mm(mk(30))});

        // Engine backpressure on both handshakes
        op_delay  = 4;
        res_delay = 3;
        preload(0, 8'd10, mk(100));
        preload(0, 8'd11, mk(200));
        h0 = hs_cnt;
        start(8'd10, 8'd20, 9'd2, 8'd0, 8'd0);
        wait_idle(200, "t3_finish");
        chk("t3_handshakes", hs_cnt - h0, 2);
        chk("t3_stable", stab_err, 0);
        chk("t3_line20", mem[0][20][127:0], mm(mk(100)));
        chk("t3_line21", mem[0][21][127:0], mm(mk(200)));
        chk("t3_jobs", host_regs_data_out[2], 2);
        op_delay  = 0;
        res_delay = 0;

        // Zero-length batch
        r0 = rd_log.size();
        w0 = wr_log.size();
        start(8'd0, 8'd0, 9'd0, 8'd0, 8'd1);
        chk("t4_done", host_regs_data_out[1], 1);
        chk("t4_busy", host_regs_data_out[0], 1);
        chk("t4_jobs", host_regs_data_out[2], 0);
        tick(1);
        chk("t4_idle", host_regs_data_out[0], 0);
        chk("t4_no_strobes", {rd_log.size() - r0, wr_log.size() - w0}, 0);

        // Illegal memory index
        start(8'd0, 8'd0, 9'd1, 8'd0, 8'd2);
        chk("t5_err", host_regs_data_out[3], 2'b10);
        chk("t5_busy", host_regs_data_out[0], 0);
        chk("t5_done_kept", host_regs_data_out[1], 1);
        tick(2);
        chk("t5_still_idle", host_regs_data_out[0], 0);

        // Start while busy
        preload(1, 8'd40, mk(7));
        start(8'd40, 8'd41, 9'd1, 8'd1, 8'd1);
        chk("t6_err_cleared", host_regs_data_out[3], 0);
        start(8'd0, 8'd0, 9'd5, 8'd0, 8'd0);
        chk("t6_err_busy", host_regs_data_out[3], 2'b01);
        wait_idle(50, "t6_finish");
        chk("t6_jobs", host_regs_data_out[2], 1);
        chk("t6_line", mem[1][41][127:0], mm(mk(7)));

        // Reset in the middle of job 2 of 4
        preload(0, 8'd50, mk(300));
        preload(0, 8'd51, mk(310));
        preload(0, 8'd52, mk(320));
        preload(0, 8'd53, mk(330));
        start(8'd50, 8'd60, 9'd4, 8'd0, 8'd1);
        reached = 1'b0;
        for (int c = 0; c < 60 && !reached; c++) begin
            tick(1);
            if (host_regs_data_out[2] == 1 && eng_op_valid)
                reached = 1'b1;
        end
        chk("t7_reached_issue", reached, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_strobes", strobes(), 0);
        chk("t7_wdata1", xlr_mem_wdata[1], 0);
        chk("t7_eng", {eng_op_valid, eng_res_ready}, 0);
        chk("t7_status",
            {host_regs_data_out[0], host_regs_data_out[1],
             host_regs_data_out[2], host_regs_data_out[3]}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        r0 = rd_log.size();
        h0 = hs_cnt;
        start(8'd50, 8'd70, 9'd2, 8'd0, 8'd1);
        wait_idle(50, "t7_finish");
        chk("t7_jobs", host_regs_data_out[2], 2);
        chk("t7_first_rd", rd_log[r0], 50);
        chk("t7_handshakes", hs_cnt - h0, 2);
        chk("t7_line70", mem[1][70][127:0], mm(mk(300)));
        chk("t7_line71", mem[1][71][127:0], mm(mk(310)));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
